// File: rtl/dnn_mmap_ctrl.sv
// dnn_mmap_ctrl: CPU register slave and start/busy/done job controller for a DNN core, plus
// zero-latency word-to-byte address mapping of its memory ports. Optional IRQ: `define DNN_MMAP_IRQ_EN.
module dnn_mmap_ctrl #(
    parameter int          NUM_CFG   = 12,
    parameter int          NUM_PORTS = 3,
    parameter int          ACC_AW    = 16,
    parameter logic [31:0] ADDR_MASK = 32'h0000_ffff
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_valid,
    input  logic [31:0]                 i_addr,
    input  logic [3:0]                  i_wstrb,
    input  logic [31:0]                 i_wdata,
    output logic                        o_ready,
    output logic [31:0]                 o_rdata,
    output logic [NUM_CFG*32-1:0]       o_cfg,
    output logic                        o_acc_start,
    output logic                        o_acc_mode,
    output logic                        o_acc_abort,
    input  logic                        i_acc_done,
    input  logic [NUM_PORTS-1:0]        i_acc_req,
    input  logic [NUM_PORTS*ACC_AW-1:0] i_acc_addr,
    input  logic [NUM_PORTS-1:0]        i_acc_wen,
    input  logic [NUM_PORTS*32-1:0]     i_acc_wdata,
    output logic [NUM_PORTS*32-1:0]     o_acc_rdata,
    output logic [NUM_PORTS-1:0]        o_acc_ack,
    output logic [NUM_PORTS-1:0]        o_mem_valid,
    output logic [NUM_PORTS-1:0]        o_mem_write,
    output logic [NUM_PORTS*32-1:0]     o_mem_addr,
    output logic [NUM_PORTS*32-1:0]     o_mem_wdata,
    input  logic [NUM_PORTS-1:0]        i_mem_ready,
    input  logic [NUM_PORTS*32-1:0]     i_mem_rdata
`ifdef DNN_MMAP_IRQ_EN
    ,
    output logic                        o_irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cfg  [NUM_CFG];
    logic [31:0] r_base [NUM_PORTS];
    logic        r_mode, r_done, r_err, r_abt;
    logic        r_ready, r_acc_start, r_acc_abort;
    logic [31:0] r_rdata;
`ifdef DNN_MMAP_IRQ_EN
    logic [2:0]  r_irq_en;
    logic        r_irq;
`endif

    logic                 w_acc, w_wr, w_rd, w_busy;
    logic [31:0]          w_off, w_rdata;
    logic                 w_hit_status, w_hit_ctrl, w_hit_irqen, w_hit_any;
    logic [NUM_PORTS-1:0] w_sel_base;
    logic [NUM_CFG-1:0]   w_sel_cfg;
    logic                 w_ctrl_wr, w_start, w_abort, w_lock_err;
    logic                 w_set_err, w_set_done, w_clr;

    function automatic logic [31:0] f_wmerge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Bus decode; while a job runs, config/base/mode/start writes are refused and flagged as errors.
    always_comb begin
        w_acc        = i_en & i_valid & ~r_ready;
        w_wr         = w_acc & (i_wstrb != 4'b0000);
        w_rd         = w_acc & (i_wstrb == 4'b0000);
        w_off        = i_addr & ADDR_MASK;
        w_busy       = (r_state == ST_RUN);
        w_hit_status = (w_off == 32'h0000_0000);
        w_hit_ctrl   = (w_off == 32'h0000_0004);
`ifdef DNN_MMAP_IRQ_EN
        w_hit_irqen  = (w_off == 32'h0000_0008);
`else
        w_hit_irqen  = 1'b0;
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_base[p] = (w_off == (32'h0000_0010 + 32'(4 * p)));
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            w_sel_cfg[i] = (w_off == (32'h0000_0040 + 32'(4 * i)));
        end
        w_hit_any  = w_hit_status | w_hit_ctrl | w_hit_irqen | (|w_sel_base) | (|w_sel_cfg);
        w_ctrl_wr  = w_wr & w_hit_ctrl & i_wstrb[0];
        w_start    = w_ctrl_wr & i_wdata[0] & ~w_busy;
        w_abort    = w_ctrl_wr & i_wdata[2] & w_busy;
        w_lock_err = w_wr & w_busy & ((|w_sel_base) | (|w_sel_cfg) |
                     (w_ctrl_wr & (i_wdata[0] | (i_wdata[1] != r_mode))));
        w_set_err  = (w_acc & ~w_hit_any) | w_lock_err;
        w_clr      = w_rd & w_hit_status;
    end

    // Read-data mux; unmapped offsets return zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        w_rdata = w_rdata | (w_hit_status ? {28'h000_0000, r_abt, r_err, w_busy, r_done} : 32'h0000_0000);
        w_rdata = w_rdata | (w_hit_ctrl ? {30'h0000_0000, r_mode, 1'b0} : 32'h0000_0000);
`ifdef DNN_MMAP_IRQ_EN
        w_rdata = w_rdata | (w_hit_irqen ? {29'h0000_0000, r_irq_en} : 32'h0000_0000);
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rdata = w_rdata | (w_sel_base[p] ? r_base[p] : 32'h0000_0000);
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            w_rdata = w_rdata | (w_sel_cfg[i] ? r_cfg[i] : 32'h0000_0000);
        end
    end

    // Job FSM next state; DONE lasts one cycle and behaves like IDLE for a new start.
    always_comb begin
        w_state_nxt = r_state;
        w_set_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_RUN;
                else         w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_acc_done) begin
                    w_state_nxt = ST_DONE;
                    w_set_done  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_start) w_state_nxt = ST_RUN;
                else         w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state, handshake and sticky flags (a same-cycle set beats the STATUS-read clear).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_acc_start <= 1'b0;
            r_acc_abort <= 1'b0;
            r_mode      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_abt       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= w_acc;
            r_rdata     <= w_rd ? w_rdata : 32'h0000_0000;
            r_acc_start <= w_start;
            r_acc_abort <= w_abort;
            if (w_ctrl_wr && !w_busy) r_mode <= i_wdata[1];
            r_done      <= (r_done & ~w_clr) | w_set_done;
            r_err       <= (r_err & ~w_clr) | w_set_err;
            r_abt       <= (r_abt & ~w_clr) | w_abort;
        end
    end

    // Config and port-base register files with byte-lane writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CFG; i++)   r_cfg[i]  <= 32'h0000_0000;
            for (int p = 0; p < NUM_PORTS; p++) r_base[p] <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (w_wr && !w_busy && w_sel_cfg[i]) r_cfg[i] <= f_wmerge(r_cfg[i], i_wdata, i_wstrb);
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_wr && !w_busy && w_sel_base[p]) r_base[p] <= f_wmerge(r_base[p], i_wdata, i_wstrb);
            end
        end
    end

`ifdef DNN_MMAP_IRQ_EN
    // Interrupt enable register and registered interrupt (lags the flags by one cycle).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_en <= 3'b000;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && w_hit_irqen && i_wstrb[0]) r_irq_en <= i_wdata[2:0];
            r_irq <= |(r_irq_en & {r_abt, r_err, r_done});
        end
    end

    assign o_irq = r_irq;
`endif

    // Memory-port mapping: word address scaled to bytes plus per-port base, wrapping at 2^32.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_mem_addr[32*p +: 32] = r_base[p] + 32'({i_acc_addr[ACC_AW*p +: ACC_AW], 2'b00});
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            o_cfg[32*i +: 32] = r_cfg[i];
        end
    end

    assign o_mem_valid = i_acc_req;
    assign o_mem_write = i_acc_wen;
    assign o_mem_wdata = i_acc_wdata;
    assign o_acc_rdata = i_mem_rdata;
    assign o_acc_ack   = i_mem_ready;
    assign o_ready     = r_ready;
    assign o_rdata     = r_rdata;
    assign o_acc_start = r_acc_start;
    assign o_acc_abort = r_acc_abort;
    assign o_acc_mode  = r_mode;

endmodule

// File: tb/tb_dnn_mmap_ctrl.sv
// Directed self-checking bench for dnn_mmap_ctrl with default parameters (12 CFG, 3 ports, 16-bit acc addr).
module tb_dnn_mmap_ctrl;

    logic         clk, rst, en, valid;
    logic [31:0]  addr, wdata;
    logic [3:0]   wstrb;
    logic         ready;
    logic [31:0]  rdata;
    logic [383:0] cfg;
    logic         acc_start, acc_mode, acc_abort, acc_done;
    logic [2:0]   acc_req, acc_wen, acc_ack, mem_valid, mem_write, mem_ready;
    logic [47:0]  acc_addr;
    logic [95:0]  acc_wdata, acc_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DNN_MMAP_IRQ_EN
    logic         irq;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_v;
    logic        s_start, s_abort, s_start2, s_abort2, s_irq, s_irq2;

    dnn_mmap_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_addr(addr),
        .i_wstrb(wstrb), .i_wdata(wdata), .o_ready(ready), .o_rdata(rdata), .o_cfg(cfg),
        .o_acc_start(acc_start), .o_acc_mode(acc_mode), .o_acc_abort(acc_abort),
        .i_acc_done(acc_done), .i_acc_req(acc_req), .i_acc_addr(acc_addr), .i_acc_wen(acc_wen),
        .i_acc_wdata(acc_wdata), .o_acc_rdata(acc_rdata), .o_acc_ack(acc_ack),
        .o_mem_valid(mem_valid), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
`ifdef DNN_MMAP_IRQ_EN
        , .o_irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access: accept edge, ready/rdata sampled after it, ready must drop one cycle later.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic with_done);
        @(negedge clk);
        en = 1'b1; valid = 1'b1; addr = a; wstrb = s; wdata = d; acc_done = with_done;
        @(posedge clk); #1;
        en = 1'b0; valid = 1'b0; wstrb = 4'h0; acc_done = 1'b0;
        check_val("ready_pulse", {31'd0, ready}, 32'd1);
        rd_v = rdata; s_start = acc_start; s_abort = acc_abort;
`ifdef DNN_MMAP_IRQ_EN
        s_irq = irq;
`else
        s_irq = 1'b0;
`endif
        @(posedge clk); #1;
        check_val("ready_drop", {31'd0, ready}, 32'd0);
        s_start2 = acc_start; s_abort2 = acc_abort;
`ifdef DNN_MMAP_IRQ_EN
        s_irq2 = irq;
`else
        s_irq2 = 1'b0;
`endif
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus(a, s, d, 1'b0);
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus(a, 4'h0, 32'h0, 1'b0);
        check_val(tag, rd_v, exp);
    endtask

    task automatic pulse_done();
        @(negedge clk); acc_done = 1'b1;
        @(negedge clk); acc_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; addr = 32'h0; wstrb = 4'h0; wdata = 32'h0;
        acc_done = 1'b0; acc_req = 3'b000; acc_addr = 48'h0; acc_wen = 3'b000;
        acc_wdata = 96'h0; mem_ready = 3'b000; mem_rdata = 96'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_ctl_outs", {29'd0, acc_start, acc_mode, acc_abort}, 32'h0);
        check_val("rst_cfg0", cfg[31:0], 32'h0);
        @(negedge clk); rst = 1'b0;

        // Config write/readback and byte strobes
        bus_wr(32'h40, 4'hF, 32'h0000_0005);
        bus_rd(32'h40, 32'h0000_0005, "cfg0_rd");
        bus_wr(32'h40, 4'b0010, 32'hAABB_CCDD);
        bus_rd(32'h40, 32'h0000_CC05, "cfg0_strb");
        check_val("cfg0_port", cfg[31:0], 32'h0000_CC05);
        bus_rd(32'h1234_0040, 32'h0000_CC05, "addr_mask");
        bus_rd(32'h0, 32'h0, "status_clean");

        // Address mapping and pass-through
        bus_wr(32'h18, 4'hF, 32'h0000_2000);
        bus_wr(32'h14, 4'hF, 32'hFFFF_FFF0);
        @(negedge clk);
        acc_addr = {16'h0003, 16'h0008, 16'hFFFF}; acc_req = 3'b100;
        acc_wen = 3'b101; acc_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mem_ready = 3'b010; mem_rdata = {32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
        #1;
        check_val("map_p2", mem_addr[95:64], 32'h0000_200C);
        check_val("map_p1_wrap", mem_addr[63:32], 32'h0000_0010);
        check_val("map_p0", mem_addr[31:0], 32'h0003_FFFC);
        check_val("mem_valid", {29'd0, mem_valid}, 32'h4);
        check_val("mem_write", {29'd0, mem_write}, 32'h5);
        check_val("mem_wdata1", mem_wdata[63:32], 32'h2222_2222);
        check_val("acc_rdata2", acc_rdata[95:64], 32'hC0C0_C0C0);
        check_val("acc_ack", {29'd0, acc_ack}, 32'h2);
        bus_rd(32'h18, 32'h0000_2000, "base2_rd");

        // Normal job in conv mode
        bus_wr(32'h4, 4'hF, 32'h3);
        check_val("start_pulse", {31'd0, s_start}, 32'd1);
        check_val("start_one_cycle", {31'd0, s_start2}, 32'd0);
        check_val("mode_out", {31'd0, acc_mode}, 32'd1);
        bus_rd(32'h0, 32'h2, "status_busy");
        bus_rd(32'h4, 32'h2, "ctrl_rd");
        pulse_done();
        bus_rd(32'h0, 32'h1, "status_done");
        bus_rd(32'h0, 32'h0, "status_cleared");

        // Lock while running
        bus_wr(32'h4, 4'hF, 32'h1);
        check_val("start2_pulse", {31'd0, s_start}, 32'd1);
        check_val("mode_cleared", {31'd0, acc_mode}, 32'd0);
        bus_wr(32'h44, 4'hF, 32'h0000_1234);
        bus_rd(32'h44, 32'h0, "cfg1_locked");
        bus_rd(32'h0, 32'h6, "status_lock_err");
        bus_wr(32'h4, 4'hF, 32'h1);
        check_val("no_restart", {31'd0, s_start}, 32'd0);
        bus_rd(32'h0, 32'h6, "status_restart_err");
        bus_rd(32'h0, 32'h2, "status_err_cleared");

        // Abort during run, then in idle
        bus_wr(32'h4, 4'hF, 32'h4);
        check_val("abort_pulse", {31'd0, s_abort}, 32'd1);
        check_val("abort_one_cycle", {31'd0, s_abort2}, 32'd0);
        bus_rd(32'h0, 32'h8, "status_abt");
        pulse_done();
        bus_rd(32'h0, 32'h0, "status_no_done");
        bus_wr(32'h4, 4'hF, 32'h4);
        check_val("idle_abort", {31'd0, s_abort}, 32'd0);
        bus_rd(32'h0, 32'h0, "status_idle_abort");

        // Invalid offsets
        bus_rd(32'h30, 32'h0, "unmapped_rd");
        bus_rd(32'h0, 32'h4, "status_unmapped_err");
`ifndef DNN_MMAP_IRQ_EN
        bus_wr(32'h8, 4'hF, 32'h7);
        bus_rd(32'h8, 32'h0, "irqen_unmapped");
        bus_rd(32'h0, 32'h4, "status_irqen_err");
`endif

        // acc_done coincident with clearing STATUS read: done survives
        bus_wr(32'h4, 4'hF, 32'h1);
        bus(32'h0, 4'h0, 32'h0, 1'b1);
        check_val("status_pre_done", rd_v, 32'h2);
        bus_rd(32'h0, 32'h1, "done_wins");

`ifdef DNN_MMAP_IRQ_EN
        bus_wr(32'h8, 4'hF, 32'h1);
        bus_rd(32'h8, 32'h1, "irqen_rd");
        bus_wr(32'h4, 4'hF, 32'h1);
        @(negedge clk); acc_done = 1'b1;
        @(posedge clk); #1;
        acc_done = 1'b0;
        check_val("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check_val("irq_set", {31'd0, irq}, 32'd1);
        bus_rd(32'h0, 32'h1, "status_irq");
        check_val("irq_hold", {31'd0, s_irq}, 32'd1);
        check_val("irq_fall", {31'd0, s_irq2}, 32'd0);
`endif

        // Reset in the middle of a job
        bus_wr(32'h4, 4'hF, 32'h3);
        check_val("pre_rst_mode", {31'd0, acc_mode}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_outs", {29'd0, acc_start, acc_mode, acc_abort}, 32'h0);
        check_val("midrst_cfg0", cfg[31:0], 32'h0);
        check_val("midrst_map2", mem_addr[95:64], 32'h0000_000C);
        @(negedge clk); rst = 1'b0;
        bus_rd(32'h0, 32'h0, "status_after_rst");
        check_val("no_abort_after_rst", {31'd0, s_abort}, 32'd0);
        bus_rd(32'h40, 32'h0, "cfg0_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
